// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared state encoding and register constants for the pipeline stall/flush sequencer.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_HALT     = 2'd3
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_stall_ctrl_hazard_match.sv
// Combinational source/destination comparator: flags when an enabled producer rd
// is read by the ID instruction. x0 never matches.
module pipeline_stall_ctrl_hazard_match
  import pipeline_stall_ctrl_pkg::*;
(
  input  logic       en,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_rs1,
  input  logic       use_rs2,
  output logic       match
);

  logic hit_rs1;
  logic hit_rs2;

  assign hit_rs1 = use_rs1 && (rs1 != REG_X0) && (rs1 == rd);
  assign hit_rs2 = use_rs2 && (rs2 != REG_X0) && (rs2 == rd);
  assign match   = en && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: prioritises memory holds, ID hazards and taken-branch
// flushes into pipeline-register controls, with saturating perf counters and a wait watchdog.
//
// state      | meaning
// S_IDLE     | waiting for start_i, pipeline frozen
// S_RUN      | normal issue, hazards and flushes resolved each cycle
// S_MEM_WAIT | data memory busy, counting consecutive busy cycles
// S_HALT     | watchdog expired, frozen until reset
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             idex_memread_i,
  input  logic             idex_regwrite_i,
  input  logic [4:0]       idex_rd_i,
  input  logic             exmem_memread_i,
  input  logic [4:0]       exmem_rd_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             id_branch_i,
  input  logic             branch_taken_i,
  input  logic             dmem_busy_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_hold_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [TO_W-1:0] TIMEOUT_CNT = TO_W'(TIMEOUT);

  state_e          state;
  logic [TO_W-1:0] wait_cnt;
  logic [TO_W-1:0] wait_nxt;
  logic            hz_load_use;
  logic            hz_br_alu;
  logic            hz_br_load;
  logic            hz;
  logic            active;

  pipeline_stall_ctrl_hazard_match u_match_load_use (
    .en      (idex_memread_i),
    .rd      (idex_rd_i),
    .rs1     (id_rs1_i),
    .rs2     (id_rs2_i),
    .use_rs1 (id_use_rs1_i),
    .use_rs2 (id_use_rs2_i),
    .match   (hz_load_use)
  );

  pipeline_stall_ctrl_hazard_match u_match_br_alu (
    .en      (idex_regwrite_i && id_branch_i),
    .rd      (idex_rd_i),
    .rs1     (id_rs1_i),
    .rs2     (id_rs2_i),
    .use_rs1 (id_use_rs1_i),
    .use_rs2 (id_use_rs2_i),
    .match   (hz_br_alu)
  );

  pipeline_stall_ctrl_hazard_match u_match_br_load (
    .en      (exmem_memread_i && id_branch_i),
    .rd      (exmem_rd_i),
    .rs1     (id_rs1_i),
    .rs2     (id_rs2_i),
    .use_rs1 (id_use_rs1_i),
    .use_rs2 (id_use_rs2_i),
    .match   (hz_br_load)
  );

  assign hz     = hz_load_use || hz_br_alu || hz_br_load;
  assign active = (state == S_RUN) || (state == S_MEM_WAIT);

  // The busy cycle that leaves RUN counts as the first wait cycle.
  assign wait_nxt = (state == S_MEM_WAIT) ? wait_cnt + TO_W'(1) : TO_W'(1);

  always_comb begin
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_hold_o   = 1'b1;
    if (active) begin
      pipe_hold_o = dmem_busy_i;
      if (!dmem_busy_i) begin
        if (hz) begin
          idex_bubble_o = 1'b1;
        end else begin
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
          ifid_flush_o = id_branch_i && branch_taken_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      timeout_o   <= 1'b0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) state <= S_RUN;
        end
        S_RUN, S_MEM_WAIT: begin
          if (dmem_busy_i) begin
            wait_cnt <= wait_nxt;
            if (wait_nxt >= TIMEOUT_CNT) begin
              state     <= S_HALT;
              timeout_o <= 1'b1;
            end else begin
              state <= S_MEM_WAIT;
            end
          end else begin
            wait_cnt <= '0;
            state    <= S_RUN;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase

      if (active && (dmem_busy_i || hz) && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (ifid_flush_o && (flush_cnt_o != '1))
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed and random checks of pipeline_stall_ctrl against a cycle-level behavioural model
// built from the hazard/priority rules (small counters and watchdog to reach the limits).
module tb_pipeline_stall_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             start_i;
  logic             idex_memread_i, idex_regwrite_i;
  logic [4:0]       idex_rd_i;
  logic             exmem_memread_i;
  logic [4:0]       exmem_rd_i;
  logic [4:0]       id_rs1_i, id_rs2_i;
  logic             id_use_rs1_i, id_use_rs2_i;
  logic             id_branch_i, branch_taken_i, dmem_busy_i;
  logic             pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o, timeout_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: running flag, halted flag, length of the current busy run, counters.
  bit m_started = 0;
  bit m_halted  = 0;
  int m_busy_run = 0;
  int m_stalls = 0;
  int m_flushes = 0;

  pipeline_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .idex_memread_i(idex_memread_i), .idex_regwrite_i(idex_regwrite_i), .idex_rd_i(idex_rd_i),
    .exmem_memread_i(exmem_memread_i), .exmem_rd_i(exmem_rd_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .id_branch_i(id_branch_i), .branch_taken_i(branch_taken_i), .dmem_busy_i(dmem_busy_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
    .idex_bubble_o(idex_bubble_o), .pipe_hold_o(pipe_hold_o), .timeout_o(timeout_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit id_reads(input logic [4:0] r);
    return (r != 5'd0) && ((id_use_rs1_i && id_rs1_i == r) || (id_use_rs2_i && id_rs2_i == r));
  endfunction

  function automatic bit m_hazard();
    bit load_use, br_alu, br_load;
    load_use = idex_memread_i && id_reads(idex_rd_i);
    br_alu   = id_branch_i && idex_regwrite_i && id_reads(idex_rd_i);
    br_load  = id_branch_i && exmem_memread_i && id_reads(exmem_rd_i);
    return load_use || br_alu || br_load;
  endfunction

  function automatic bit m_frozen();
    return !m_started || m_halted;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit frz, go;
    frz = m_frozen();
    go  = !frz && !dmem_busy_i && !m_hazard();
    check({tag, ".pc_write"},   int'(pc_write_o),    int'(go));
    check({tag, ".ifid_write"}, int'(ifid_write_o),  int'(go));
    check({tag, ".flush"},      int'(ifid_flush_o),  int'(go && id_branch_i && branch_taken_i));
    check({tag, ".bubble"},     int'(idex_bubble_o), int'(!frz && !dmem_busy_i && m_hazard()));
    check({tag, ".hold"},       int'(pipe_hold_o),   int'(frz || dmem_busy_i));
    check({tag, ".timeout"},    int'(timeout_o),     int'(m_halted));
    check({tag, ".stall_cnt"},  int'(stall_cnt_o),   m_stalls);
    check({tag, ".flush_cnt"},  int'(flush_cnt_o),   m_flushes);
  endtask

  task automatic model_reset();
    m_started = 0; m_halted = 0; m_busy_run = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic model_advance();
    if (!rst_i) return;
    if (!m_started) begin
      m_started = start_i;
    end else if (!m_halted) begin
      if (dmem_busy_i) begin
        m_stalls   = (m_stalls < CNT_MAX) ? m_stalls + 1 : CNT_MAX;
        m_busy_run = m_busy_run + 1;
        if (m_busy_run >= TIMEOUT) m_halted = 1;
      end else begin
        m_busy_run = 0;
        if (m_hazard())
          m_stalls = (m_stalls < CNT_MAX) ? m_stalls + 1 : CNT_MAX;
        else if (id_branch_i && branch_taken_i)
          m_flushes = (m_flushes < CNT_MAX) ? m_flushes + 1 : CNT_MAX;
      end
    end
  endtask

  task automatic step(input string tag);
    @(negedge clk_i);
    check_all(tag);
    @(posedge clk_i);
    model_advance();
    #1;
  endtask

  task automatic do_reset(input string tag);
    #2 rst_i = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
  endtask

  task automatic clr();
    start_i = 0; idex_memread_i = 0; idex_regwrite_i = 0; idex_rd_i = 0;
    exmem_memread_i = 0; exmem_rd_i = 0; id_rs1_i = 0; id_rs2_i = 0;
    id_use_rs1_i = 0; id_use_rs2_i = 0; id_branch_i = 0; branch_taken_i = 0; dmem_busy_i = 0;
  endtask

  initial begin
    clr();
    do_reset("reset");
    step("idle");
    start_i = 1; step("start");
    start_i = 0;

    // load x5 in EX, add reads x5: one bubble
    idex_memread_i = 1; idex_regwrite_i = 1; idex_rd_i = 5; id_rs1_i = 5; id_use_rs1_i = 1;
    step("load_use");
    clr(); step("after_load_use");
    check("load_use.stall_cnt", int'(stall_cnt_o), 1);

    // load x7 then beq on x7, taken: two bubbles then flush
    idex_memread_i = 1; idex_regwrite_i = 1; idex_rd_i = 7;
    id_branch_i = 1; branch_taken_i = 1; id_rs2_i = 7; id_use_rs2_i = 1; id_use_rs1_i = 1; id_rs1_i = 3;
    step("br_load.b1");
    idex_memread_i = 0; idex_regwrite_i = 0; idex_rd_i = 0; exmem_memread_i = 1; exmem_rd_i = 7;
    step("br_load.b2");
    exmem_memread_i = 0; exmem_rd_i = 0;
    step("br_load.flush");
    clr(); step("after_flush");
    check("br_load.flush_cnt", int'(flush_cnt_o), 1);
    check("br_load.stall_cnt", int'(stall_cnt_o), 3);

    // x0 never matches
    idex_memread_i = 1; idex_rd_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_use_rs1_i = 1; id_use_rs2_i = 1;
    step("x0");
    clr(); step("after_x0");
    check("x0.stall_cnt", int'(stall_cnt_o), 3);

    // busy 4 cycles over a hazard and a taken branch: hold only, hazard afterwards
    do_reset("reset2");
    start_i = 1; step("start2"); start_i = 0;
    idex_regwrite_i = 1; idex_rd_i = 9; id_branch_i = 1; branch_taken_i = 1;
    id_rs1_i = 9; id_use_rs1_i = 1; dmem_busy_i = 1;
    for (int i = 0; i < 4; i++) step("busy_hold");
    check("busy.stall_cnt", int'(stall_cnt_o), 4);
    dmem_busy_i = 0; step("busy_then_hz");
    idex_regwrite_i = 0; step("busy_then_flush");
    check("busy.stall_after", int'(stall_cnt_o), 5);
    check("busy.flush_after", int'(flush_cnt_o), 1);

    // reset in the middle of a memory wait
    clr(); dmem_busy_i = 1; step("wait1"); step("wait2");
    do_reset("mid_wait_reset");
    clr();

    // watchdog: busy held TIMEOUT cycles halts until reset
    start_i = 1; step("start3"); start_i = 0;
    dmem_busy_i = 1;
    for (int i = 0; i < TIMEOUT; i++) step("watchdog");
    check("watchdog.timeout", int'(timeout_o), 1);
    dmem_busy_i = 0; id_branch_i = 1; branch_taken_i = 1;
    for (int i = 0; i < 3; i++) step("halted");
    check("halted.hold", int'(pipe_hold_o), 1);
    check("halted.pc_write", int'(pc_write_o), 0);
    do_reset("reset_from_halt");
    check("reset.timeout", int'(timeout_o), 0);
    clr();

    // stall counter saturation
    start_i = 1; step("start4"); start_i = 0;
    idex_memread_i = 1; idex_rd_i = 4; id_rs2_i = 4; id_use_rs2_i = 1;
    for (int i = 0; i < 20; i++) step("saturate");
    check("saturate.stall_cnt", int'(stall_cnt_o), 15);
    clr();

    // random traffic with narrow register range so matches are frequent
    do_reset("reset_rand");
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset("reset_rand_mid");
      start_i         = 1'($urandom_range(0, 1));
      idex_memread_i  = 1'($urandom_range(0, 1));
      idex_regwrite_i = 1'($urandom_range(0, 1));
      idex_rd_i       = 5'($urandom_range(0, 3));
      exmem_memread_i = 1'($urandom_range(0, 1));
      exmem_rd_i      = 5'($urandom_range(0, 3));
      id_rs1_i        = 5'($urandom_range(0, 3));
      id_rs2_i        = 5'($urandom_range(0, 3));
      id_use_rs1_i    = 1'($urandom_range(0, 1));
      id_use_rs2_i    = 1'($urandom_range(0, 1));
      id_branch_i     = 1'($urandom_range(0, 1));
      branch_taken_i  = 1'($urandom_range(0, 1));
      dmem_busy_i     = ($urandom_range(0, 3) == 0);
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
